seq_frame_tx: RTL and testbench

- Serial frame transmitter; the transmit end of the serial `seq` line that the team's 1101 sequence detectors monitor.
- Accepts a parallel payload over a valid/ready handshake.
- Emits a fixed sync preamble (default 1101), MSB first, one bit per clock, followed by the payload MSB first.
- A downstream 1101 detector ticks on the last preamble bit.

---
 rtl/seq_frame_tx_if.sv | 22 ++
 rtl/seq_frame_tx.sv | 151 +++++++++++++++
 tb/tb_seq_frame_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-line bundle for seq_frame_tx.
// The master side supplies payloads; the slave side (the transmitter) drives the line.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              seq;
  logic              seq_valid;
  logic              frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, seq, seq_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, seq, seq_valid, frame_done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble then payload, MSB first, one bit per clock.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b1101
) (
  input logic            clk,
  input logic            rst,
  seq_frame_tx_if.slave  bus
);

  localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [PRE_W-1:0]  pre_sr, pre_d;
  logic [DATA_W-1:0] data_sr, data_d;
  logic              seq_q, seq_d;
  logic              seq_valid_q, seq_valid_d;
  logic              done_q, done_d;
  logic              last_bit;
  logic              in_ready;
  logic              accept;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Shift registers hold the bits still to be sent after the one currently on seq.
`ifdef SEQ_FRAME_TX_PARITY_EN
  assign last_bit = (state == PAR);
`else
  assign last_bit = (state == DATA) && (cnt == '0);
`endif
  assign in_ready = rst && ((state == IDLE) || last_bit);
  assign accept   = in_ready && bus.in_valid;

  assign bus.in_ready   = in_ready;
  assign bus.seq        = seq_q;
  assign bus.seq_valid  = seq_valid_q;
  assign bus.frame_done = done_q;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pre_d       = pre_sr;
    data_d      = data_sr;
    seq_d       = 1'b0;
    seq_valid_d = 1'b0;
    done_d      = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_d       = par_q;
`endif
    case (state)
      IDLE: begin
        state_d = IDLE;
      end
      PRE: begin
        seq_valid_d = 1'b1;
        if (cnt == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LAST;
          seq_d   = data_sr[DATA_W-1];
          data_d  = data_sr << 1;
        end else begin
          cnt_d   = cnt - 1'b1;
          seq_d   = pre_sr[PRE_W-1];
          pre_d   = pre_sr << 1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d     = PAR;
          seq_d       = par_q;
          seq_valid_d = 1'b1;
          done_d      = 1'b1;
`else
          state_d     = IDLE;
`endif
        end else begin
          cnt_d       = cnt - 1'b1;
          seq_d       = data_sr[DATA_W-1];
          data_d      = data_sr << 1;
          seq_valid_d = 1'b1;
`ifndef SEQ_FRAME_TX_PARITY_EN
          done_d      = (cnt == CNT_W'(1));
`endif
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      PAR: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new payload is only taken in IDLE or the last bit, so it overrides the frame end.
    if (accept) begin
      state_d     = PRE;
      cnt_d       = PRE_LAST;
      seq_d       = PREAMBLE[PRE_W-1];
      pre_d       = PREAMBLE << 1;
      data_d      = bus.in_data;
      seq_valid_d = 1'b1;
      done_d      = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_d       = ^bus.in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pre_sr      <= '0;
      data_sr     <= '0;
      seq_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pre_sr      <= pre_d;
      data_sr     <= data_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      done_q      <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed self-checking bench for seq_frame_tx with hand-computed frame bit patterns.
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int F = 13;
  localparam logic [F-1:0] EXP_A5 = {4'b1101, 8'hA5, 1'b0};
  localparam logic [F-1:0] EXP_3C = {4'b1101, 8'h3C, 1'b0};
  localparam logic [F-1:0] EXP_FF = {4'b1101, 8'hFF, 1'b0};
  localparam logic [F-1:0] EXP_81 = {4'b1101, 8'h81, 1'b0};
  localparam logic [F-1:0] EXP_07 = {4'b1101, 8'h07, 1'b1};
`else
  localparam int F = 12;
  localparam logic [F-1:0] EXP_A5 = {4'b1101, 8'hA5};
  localparam logic [F-1:0] EXP_3C = {4'b1101, 8'h3C};
  localparam logic [F-1:0] EXP_FF = {4'b1101, 8'hFF};
  localparam logic [F-1:0] EXP_81 = {4'b1101, 8'h81};
  localparam logic [F-1:0] EXP_07 = {4'b1101, 8'h07};
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] hist;

  seq_frame_tx_if #(.DATA_W(8)) bus ();

  seq_frame_tx #(.DATA_W(8), .PRE_W(4), .PREAMBLE(4'b1101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkOutput($sformatf("%s seq c%0d", tag, i), 16'(bus.seq), 16'd0);
      checkOutput($sformatf("%s seq_valid c%0d", tag, i), 16'(bus.seq_valid), 16'd0);
      checkOutput($sformatf("%s frame_done c%0d", tag, i), 16'(bus.frame_done), 16'd0);
      checkOutput($sformatf("%s in_ready c%0d", tag, i), 16'(bus.in_ready), 16'd1);
    end
  endtask

  // Caller has set in_valid/in_data for the accepting edge; the next edge starts the frame.
  task automatic applyStimulus(input string tag, input logic [F-1:0] bits, input int validFrom,
                               input logic [7:0] nextData, input int abortAt);
    hist = 4'b0000;
    stepCycle();
    for (int k = 0; k < F; k++) begin
      checkOutput($sformatf("%s seq b%0d", tag, k), 16'(bus.seq), 16'(bits[F-1-k]));
      checkOutput($sformatf("%s seq_valid b%0d", tag, k), 16'(bus.seq_valid), 16'd1);
      checkOutput($sformatf("%s frame_done b%0d", tag, k), 16'(bus.frame_done), 16'(k == F-1));
      checkOutput($sformatf("%s in_ready b%0d", tag, k), 16'(bus.in_ready), 16'(k == F-1));
      hist = {hist[2:0], bus.seq};
      if (k <= 3)
        checkOutput($sformatf("%s tick b%0d", tag, k), 16'(hist == 4'b1101), 16'(k == 3));
      if (k == abortAt) begin
        #2 rst = 1'b0;
        #1;
        checkOutput({tag, " seq async"}, 16'(bus.seq), 16'd0);
        checkOutput({tag, " seq_valid async"}, 16'(bus.seq_valid), 16'd0);
        checkOutput({tag, " frame_done async"}, 16'(bus.frame_done), 16'd0);
        checkOutput({tag, " in_ready async"}, 16'(bus.in_ready), 16'd0);
        return;
      end
      bus.in_valid = (k >= validFrom);
      bus.in_data  = nextData;
      if (k < F-1) stepCycle();
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset seq", 16'(bus.seq), 16'd0);
      checkOutput("reset seq_valid", 16'(bus.seq_valid), 16'd0);
      checkOutput("reset frame_done", 16'(bus.frame_done), 16'd0);
      checkOutput("reset in_ready", 16'(bus.in_ready), 16'd0);
    end
    rst = 1'b1;
    checkIdle("idle", 10);

    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    applyStimulus("single", EXP_A5, F, 8'h00, -1);
    checkIdle("after single", 2);

    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    applyStimulus("b2b first", EXP_A5, 0, 8'h3C, -1);
    applyStimulus("b2b second", EXP_3C, F, 8'h00, -1);
    checkIdle("after b2b", 2);

    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    applyStimulus("bp first", EXP_A5, 4, 8'hFF, -1);
    applyStimulus("bp second", EXP_FF, F, 8'h00, -1);
    checkIdle("after bp", 2);

    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    applyStimulus("abort", EXP_A5, F, 8'h00, 6);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort hold seq_valid", 16'(bus.seq_valid), 16'd0);
      checkOutput("abort hold seq", 16'(bus.seq), 16'd0);
    end
    rst = 1'b1;
    checkIdle("after abort", 2);
    bus.in_data  = 8'h81;
    bus.in_valid = 1'b1;
    applyStimulus("fresh 81", EXP_81, F, 8'h00, -1);
    checkIdle("after 81", 2);

    bus.in_data  = 8'h07;
    bus.in_valid = 1'b1;
    applyStimulus("frame 07", EXP_07, F, 8'h00, -1);
    checkIdle("after 07", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
